// File: rtl/dtree_pkg.sv
// Shared types and defaults for the decision-tree feature driver.
// Holds the FSM state encoding and the out-of-range label check.
package dtree_pkg;

    localparam int unsigned FEAT_W_DEF = 8;
    localparam int unsigned OUT_W_DEF  = 4;

    typedef enum logic [1:0] {
        SHIFT,
        SETTLE,
        OUT
    } state_t;

    function automatic logic is_bad_label(input logic [31:0] label, input int unsigned n);
        return (label >= n);
    endfunction

endpackage

// File: rtl/dtree_feat_shifter.sv
// Bit-serial deserialiser: MSB-first shift register plus bit counter.
// The final bit of a word is held off while stall is high, so earlier bits can still arrive.
module dtree_feat_shifter #(
    parameter int unsigned FEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_data,
    input  logic              stall,
    output logic              s_ready,
    output logic              word_done,
    output logic [FEAT_W-1:0] word
);

    localparam int unsigned CW = (FEAT_W > 2) ? $clog2(FEAT_W) : 1;

    logic [CW-1:0]     cnt;
    logic [FEAT_W-2:0] shreg;
    logic              last;
    logic              accept;

    assign last      = (cnt == CW'(FEAT_W - 1));
    assign s_ready   = !stall || !last;
    assign accept    = s_valid && s_ready;
    assign word_done = accept && last;
    assign word      = {shreg, s_data};

    // Counter wraps at FEAT_W-1, not at the natural power-of-two overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            shreg <= word[FEAT_W-2:0];
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dtree_feature_driver.sv
// Producer side of the tree feature interface: deserialise, drive the tree,
// wait for the slow combinational path to settle, then hand the label downstream.
module dtree_feature_driver
    import dtree_pkg::*;
#(
    parameter int unsigned FEAT_W        = FEAT_W_DEF,
    parameter int unsigned OUT_W         = OUT_W_DEF,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_CLASSES   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_data,
    output logic              s_ready,
    output logic [FEAT_W-1:0] feat_o,
    input  logic [OUT_W-1:0]  tree_out_i,
    output logic              m_valid,
    output logic [OUT_W-1:0]  m_class,
    output logic              m_err,
    input  logic              m_ready,
    output logic              busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_t            state;
    logic [SW-1:0]     settle;
    logic              word_done;
    logic [FEAT_W-1:0] word;

    assign busy = (state != SHIFT);

    dtree_feat_shifter #(
        .FEAT_W (FEAT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .stall     (busy),
        .s_ready   (s_ready),
        .word_done (word_done),
        .word      (word)
    );

    // word_done can only fire in SHIFT, so feat_o is frozen while a label is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SHIFT;
            settle  <= '0;
            feat_o  <= '0;
            m_valid <= 1'b0;
            m_class <= '0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (word_done) begin
                        feat_o <= word;
                        settle <= SW'(SETTLE_CYCLES - 1);
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle == '0) begin
                        m_class <= tree_out_i;
                        m_err   <= is_bad_label(32'(tree_out_i), NUM_CLASSES);
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        settle <= settle - 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_feature_driver.sv
// Scoreboard bench: stimulus pushes expected labels, negedge monitors pop on each handshake.
// A second instance with a one-cycle settle time exercises back-to-back streaming.
module tb_dtree_feature_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, s_data = 1'b0, s_ready;
    logic [7:0] feat_o;
    logic [3:0] tree_out_i;
    logic       m_valid, m_err, busy;
    logic [3:0] m_class;
    logic       m_ready = 1'b0;

    logic       s_valid1 = 1'b0, s_data1 = 1'b0, s_ready1;
    logic [7:0] feat1_o;
    logic [3:0] tree1_out;
    logic       m_valid1, m_err1, busy1;
    logic [3:0] m_class1;
    logic       m_ready1 = 1'b1;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [7:0] feat;
        logic [3:0] cls;
        logic       err;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    logic       ov_en = 1'b0;
    logic [3:0] ov_val = '0;
    logic       noise_en = 1'b0;
    logic [3:0] noise = '0;
    logic       busy_q = 1'b0;
    int         since = 0;
    int         cyc = 0;
    int         last_hs = -1;
    int         hs1 = 0;

    function automatic logic [3:0] golden(input logic [7:0] f);
        return f[7:4] ^ f[3:0];
    endfunction

    always #5 clk = ~clk;

    dtree_feature_driver #(
        .FEAT_W(8), .OUT_W(4), .SETTLE_CYCLES(4), .NUM_CLASSES(10)
    ) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .feat_o(feat_o), .tree_out_i(tree_out_i), .m_valid(m_valid), .m_class(m_class),
        .m_err(m_err), .m_ready(m_ready), .busy(busy)
    );

    dtree_feature_driver #(
        .FEAT_W(8), .OUT_W(4), .SETTLE_CYCLES(1), .NUM_CLASSES(10)
    ) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
        .feat_o(feat1_o), .tree_out_i(tree1_out), .m_valid(m_valid1), .m_class(m_class1),
        .m_err(m_err1), .m_ready(m_ready1), .busy(busy1)
    );

    // Tree model; with noise enabled it returns garbage except in the sample cycle.
    assign tree_out_i = ov_en ? ov_val :
                        (noise_en && since != 3) ? noise : golden(feat_o);
    assign tree1_out  = golden(feat1_o);

    always @(posedge clk) begin
        cyc++;
        #1;
        if (busy && !busy_q) since = 0;
        else since++;
        busy_q = busy;
        noise  = 4'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (sb0.size() == 0) begin
                chk("unexpected_result0", 32'(m_class), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                chk("m_class", 32'(m_class), 32'(e.cls));
                chk("m_err", 32'(m_err), 32'(e.err));
                chk("feat_at_out", 32'(feat_o), 32'(e.feat));
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid1 && m_ready1) begin
            hs1++;
            if (sb1.size() == 0) begin
                chk("unexpected_result1", 32'(m_class1), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                chk("m_class1", 32'(m_class1), 32'(e.cls));
                chk("m_err1", 32'(m_err1), 32'(e.err));
            end
            if (last_hs >= 0) chk("interval1", 32'(cyc - last_hs), 32'd8);
            last_hs = cyc;
        end
    end

    task automatic send_bit(input logic b);
        s_valid = 1'b1;
        s_data  = b;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("bit_accept_timeout", 32'(s_ready), 32'd1);
    endtask

    task automatic push0(input logic [7:0] f, input logic [3:0] cls);
        exp_t e;
        e.feat = f;
        e.cls  = cls;
        e.err  = (cls >= 4'd10);
        sb0.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] f, input int gapmax);
        push0(f, ov_en ? ov_val : golden(f));
        for (int i = 7; i >= 0; i--) begin
            if (gapmax > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, gapmax)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_bit(f[i]);
        end
        s_valid = 1'b0;
        chk("feat_after_8th", 32'(feat_o), 32'(f));
    endtask

    task automatic drain0();
        for (int w = 0; w < 100 && sb0.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        chk("drain0", 32'(sb0.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] f;
        int stalls;
        int moved;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_class", 32'(m_class), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_feat_o", 32'(feat_o), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // 1: 0xA5, tree returns 3, check latency
        ov_en  = 1'b1;
        ov_val = 4'd3;
        f = 8'hA5;
        push0(f, 4'd3);
        for (int i = 7; i >= 0; i--) send_bit(f[i]);
        s_valid = 1'b0;
        chk("t1_feat", 32'(feat_o), 32'hA5);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("t1_m_valid_early", 32'(m_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_m_class", 32'(m_class), 32'd3);
        chk("t1_m_err", 32'(m_err), 32'd0);

        // 2: back-pressure, next sample stalls on its 8th bit
        ov_val = 4'd12;
        f = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(f[i]);
        s_valid = 1'b1;
        s_data  = f[0];
        stalls  = 0;
        moved   = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (!s_ready) stalls++;
            if (feat_o != 8'hA5 || !m_valid || m_class != 4'd3) moved++;
        end
        chk("t2_stalled", 32'(stalls), 32'd15);
        chk("t2_held", 32'(moved), 32'd0);
        @(posedge clk);
        #1;
        push0(f, 4'd12);
        m_ready = 1'b1;
        @(negedge clk);
        chk("t2_sready_hs", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_m_valid_drop", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t2_sready_after", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_feat", 32'(feat_o), 32'h5A);
        drain0();

        // 3: label 9 is in range
        ov_val = 4'd9;
        send_byte(8'h77, 0);
        drain0();
        ov_en = 1'b0;

        // 4: reset after 5 bits
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t4_m_valid", 32'(m_valid), 32'd0);
        chk("t4_feat", 32'(feat_o), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("t4_no_output", 32'(m_valid), 32'd0);
        send_byte(8'h3C, 0);
        drain0();

        // 5: gaps and tree noise outside the sample cycle
        send_byte(8'hF0, 0);
        drain0();
        noise_en = 1'b1;
        send_byte(8'hF0, 3);
        drain0();
        send_byte(8'h92, 2);
        drain0();
        noise_en = 1'b0;

        // 6: SETTLE_CYCLES=1, continuous stream of random features
        stalls = 0;
        for (int n = 0; n < 100; n++) begin
            exp_t e;
            f = 8'($urandom);
            e.feat = f;
            e.cls  = golden(f);
            e.err  = (golden(f) >= 4'd10);
            sb1.push_back(e);
            for (int i = 7; i >= 0; i--) begin
                s_valid1 = 1'b1;
                s_data1  = f[i];
                @(negedge clk);
                if (!s_ready1) stalls++;
                @(posedge clk);
                #1;
            end
        end
        s_valid1 = 1'b0;
        for (int w = 0; w < 50 && sb1.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        chk("drain1", 32'(sb1.size()), 32'd0);
        chk("t6_stalls", 32'(stalls), 32'd0);
        chk("t6_results", 32'(hs1), 32'd100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
